time_of_day_counter: RTL and testbench

//   BCD hours:minutes:seconds counter for the digital clock. Feeds the hourly

---
 rtl/time_of_day_counter_if.sv | 43 ++++
 rtl/time_of_day_counter.sv | 96 +++++++++
 tb/tb_time_of_day_counter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/time_of_day_counter_if.sv
// Time-of-day counter bus: set/tick controls in, packed-BCD time out.
// PM exists only when CLOCK_12H_EN is defined.
interface time_of_day_counter_if;
  logic       TICK_1HZ;
  logic       SET_H;
  logic       SET_M;
  logic       CLR_S;
  logic [7:0] TIME_H;
  logic [7:0] TIME_M;
  logic [7:0] TIME_S;
  logic       CARRY_H;
`ifdef CLOCK_12H_EN
  logic       PM;
`endif

  modport master (
    output TICK_1HZ,
    output SET_H,
    output SET_M,
    output CLR_S,
`ifdef CLOCK_12H_EN
    input  PM,
`endif
    input  TIME_H,
    input  TIME_M,
    input  TIME_S,
    input  CARRY_H
  );

  modport slave (
    input  TICK_1HZ,
    input  SET_H,
    input  SET_M,
    input  CLR_S,
`ifdef CLOCK_12H_EN
    output PM,
`endif
    output TIME_H,
    output TIME_M,
    output TIME_S,
    output CARRY_H
  );
endinterface

// File: rtl/time_of_day_counter.sv
// Packed-BCD hh:mm:ss counter with push-button setting.
// Define CLOCK_12H_EN for 12-hour counting with a PM flag.
module time_of_day_counter #(
  parameter logic [7:0] INIT_H = 8'h00,
  parameter logic [7:0] INIT_M = 8'h00,
  parameter logic [7:0] INIT_S = 8'h00
) (
  input logic                 CP,
  input logic                 RST,
  time_of_day_counter_if.slave tod
);

`ifdef CLOCK_12H_EN
  localparam logic [7:0] H_TOP  = 8'h12;
  localparam logic [7:0] H_WRAP = 8'h01;
`else
  localparam logic [7:0] H_TOP  = 8'h23;
  localparam logic [7:0] H_WRAP = 8'h00;
`endif

  // Digit-wise increment: units 9 rolls to 0 and bumps tens.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] t;
    logic [3:0] u;
    t = v[7:4];
    u = v[3:0];
    if (u == 4'd9) begin
      u = 4'd0;
      t = t + 4'd1;
    end else begin
      u = u + 4'd1;
    end
    return {t, u};
  endfunction

  logic [7:0] h_q, m_q, s_q;
  logic [7:0] h_nxt, m_nxt, s_nxt;
  logic       carry_q, carry_nxt;
  logic       c_s, c_m;
`ifdef CLOCK_12H_EN
  logic       pm_q, pm_nxt;
`endif

  // Next-state: cascaded carries plus set buttons, one increment per field.
  always_comb begin
    c_s   = tod.TICK_1HZ & ~tod.CLR_S & (s_q == 8'h59);
    c_m   = c_s & (m_q == 8'h59);
    s_nxt = s_q;
    m_nxt = m_q;
    h_nxt = h_q;
    if (tod.CLR_S)
      s_nxt = 8'h00;
    else if (tod.TICK_1HZ)
      s_nxt = (s_q == 8'h59) ? 8'h00 : bcd_inc(s_q);
    if (c_s | tod.SET_M)
      m_nxt = (m_q == 8'h59) ? 8'h00 : bcd_inc(m_q);
    if (c_m | tod.SET_H)
      h_nxt = (h_q == H_TOP) ? H_WRAP : bcd_inc(h_q);
`ifdef CLOCK_12H_EN
    pm_nxt    = pm_q ^ (c_m & (h_q == 8'h11));
    carry_nxt = c_m & (h_q == 8'h11) & pm_q;
`else
    carry_nxt = c_m & (h_q == 8'h23);
`endif
  end

  // Time registers; reset wins over every other input.
  always_ff @(posedge CP) begin
    if (RST) begin
      h_q     <= INIT_H;
      m_q     <= INIT_M;
      s_q     <= INIT_S;
      carry_q <= 1'b0;
`ifdef CLOCK_12H_EN
      pm_q    <= 1'b0;
`endif
    end else begin
      h_q     <= h_nxt;
      m_q     <= m_nxt;
      s_q     <= s_nxt;
      carry_q <= carry_nxt;
`ifdef CLOCK_12H_EN
      pm_q    <= pm_nxt;
`endif
    end
  end

  assign tod.TIME_H  = h_q;
  assign tod.TIME_M  = m_q;
  assign tod.TIME_S  = s_q;
  assign tod.CARRY_H = carry_q;
`ifdef CLOCK_12H_EN
  assign tod.PM      = pm_q;
`endif

endmodule

// File: tb/tb_time_of_day_counter.sv
// Directed-vector bench for time_of_day_counter.
// Positions the clock with reset/set buttons, then checks each scenario.
module tb_time_of_day_counter;

  logic CP = 1'b0;
  logic RST = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  time_of_day_counter_if tod ();

  time_of_day_counter #(
    .INIT_H(8'h12),
    .INIT_M(8'h34),
    .INIT_S(8'h56)
  ) dut (
    .CP (CP),
    .RST(RST),
    .tod(tod)
  );

  always #5 CP = ~CP;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CP);
    #1;
  endtask

  task automatic pulse(input logic t, input logic sh,
                       input logic sm, input logic cs);
    tod.TICK_1HZ = t;
    tod.SET_H    = sh;
    tod.SET_M    = sm;
    tod.CLR_S    = cs;
    cyc();
    tod.TICK_1HZ = 1'b0;
    tod.SET_H    = 1'b0;
    tod.SET_M    = 1'b0;
    tod.CLR_S    = 1'b0;
  endtask

  function automatic int b2i(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [23:0] now();
    return {tod.TIME_H, tod.TIME_M, tod.TIME_S};
  endfunction

  // Reset to 12:34:56, clear seconds, then walk each field to the target.
  task automatic goto(input logic [7:0] h, input logic [7:0] m,
                      input logic [7:0] s);
    int nh;
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    pulse(0, 0, 0, 1);
    for (int i = 0; i < (b2i(m) + 60 - 34) % 60; i++) pulse(0, 0, 1, 0);
`ifdef CLOCK_12H_EN
    nh = b2i(h) % 12;
`else
    nh = (b2i(h) + 24 - 12) % 24;
`endif
    for (int i = 0; i < nh; i++) pulse(0, 1, 0, 0);
    for (int i = 0; i < b2i(s); i++) pulse(1, 0, 0, 0);
    chk("goto", now(), {h, m, s});
  endtask

  initial begin
    tod.TICK_1HZ = 1'b0;
    tod.SET_H    = 1'b0;
    tod.SET_M    = 1'b0;
    tod.CLR_S    = 1'b0;
    cyc();

    RST = 1'b1;
    cyc();
    RST = 1'b0;
    chk("rst_h", tod.TIME_H, 8'h12);
    chk("rst_m", tod.TIME_M, 8'h34);
    chk("rst_s", tod.TIME_S, 8'h56);
    chk("rst_carry", tod.CARRY_H, 1'b0);
    cyc();
    chk("rst_hold", now(), 24'h123456);

`ifndef CLOCK_12H_EN
    goto(8'h00, 8'h00, 8'h09);
    pulse(1, 0, 0, 0);
    chk("s_digit", now(), 24'h000010);

    goto(8'h00, 8'h09, 8'h59);
    pulse(1, 0, 0, 0);
    chk("m_digit", now(), 24'h001000);

    goto(8'h23, 8'h59, 8'h59);
    chk("pre_wrap_carry", tod.CARRY_H, 1'b0);
    pulse(1, 0, 0, 0);
    chk("day_wrap", now(), 24'h000000);
    chk("day_carry", tod.CARRY_H, 1'b1);
    cyc();
    chk("carry_drop", tod.CARRY_H, 1'b0);
    chk("wrap_hold", now(), 24'h000000);

    goto(8'h10, 8'h59, 8'h59);
    pulse(1, 0, 1, 0);
    chk("setm_cs_59", now(), 24'h110000);

    goto(8'h10, 8'h58, 8'h59);
    pulse(1, 0, 1, 0);
    chk("setm_cs_58", now(), 24'h105900);

    goto(8'h23, 8'h15, 8'h00);
    pulse(0, 1, 0, 0);
    chk("seth_wrap", now(), 24'h001500);
    chk("seth_carry", tod.CARRY_H, 1'b0);

    goto(8'h05, 8'h59, 8'h30);
    pulse(0, 0, 1, 0);
    chk("setm_wrap", now(), 24'h050030);

    goto(8'h05, 8'h10, 8'h59);
    pulse(1, 0, 0, 1);
    chk("clr_tick", now(), 24'h051000);

    goto(8'h05, 8'h10, 8'h30);
    pulse(0, 1, 1, 1);
    chk("set_all", now(), 24'h061100);

    goto(8'h23, 8'h59, 8'h59);
    pulse(1, 1, 0, 0);
    chk("seth_cm", now(), 24'h000000);
    chk("seth_cm_carry", tod.CARRY_H, 1'b1);

    goto(8'h00, 8'h00, 8'h57);
    tod.TICK_1HZ = 1'b1;
    cyc();
    chk("held_1", tod.TIME_S, 8'h58);
    cyc();
    chk("held_2", tod.TIME_S, 8'h59);
    tod.TICK_1HZ = 1'b0;
    cyc();
    chk("held_stop", now(), 24'h000059);

    goto(8'h07, 8'h15, 8'h20);
    RST = 1'b1;
    tod.TICK_1HZ = 1'b1;
    tod.SET_H = 1'b1;
    cyc();
    RST = 1'b0;
    tod.TICK_1HZ = 1'b0;
    tod.SET_H = 1'b0;
    chk("mid_rst", now(), 24'h123456);
    chk("mid_rst_carry", tod.CARRY_H, 1'b0);

    begin
      logic [23:0] t;
      int bad;
      bad = 0;
      goto(8'h00, 8'h58, 8'h00);
      for (int i = 0; i < 3600; i++) begin
        pulse(1, 0, 0, 0);
        t = now();
        for (int d = 0; d < 6; d++)
          if (t[d*4 +: 4] > 4'd9) bad++;
      end
      chk("bcd_digits", bad, 0);
      chk("hour_run", now(), 24'h015800);
    end
`else
    goto(8'h11, 8'h59, 8'h59);
    chk("am_pm", tod.PM, 1'b0);
    pulse(1, 0, 0, 0);
    chk("to_noon", now(), 24'h120000);
    chk("noon_pm", tod.PM, 1'b1);
    chk("noon_carry", tod.CARRY_H, 1'b0);

    for (int i = 0; i < 59; i++) pulse(0, 0, 1, 0);
    for (int i = 0; i < 59; i++) pulse(1, 0, 0, 0);
    chk("pos_1259", now(), 24'h125959);
    pulse(1, 0, 0, 0);
    chk("to_one", now(), 24'h010000);
    chk("one_pm", tod.PM, 1'b1);

    for (int i = 0; i < 10; i++) pulse(0, 1, 0, 0);
    for (int i = 0; i < 59; i++) pulse(0, 0, 1, 0);
    for (int i = 0; i < 59; i++) pulse(1, 0, 0, 0);
    chk("pos_1159pm", now(), 24'h115959);
    chk("pos_pm", tod.PM, 1'b1);
    pulse(1, 0, 0, 0);
    chk("to_midnight", now(), 24'h120000);
    chk("midnight_pm", tod.PM, 1'b0);
    chk("midnight_carry", tod.CARRY_H, 1'b1);
    cyc();
    chk("carry_drop", tod.CARRY_H, 1'b0);

    pulse(0, 1, 0, 0);
    chk("seth_12_01", tod.TIME_H, 8'h01);
    chk("seth_pm", tod.PM, 1'b0);

    goto(8'h07, 8'h15, 8'h20);
    RST = 1'b1;
    tod.TICK_1HZ = 1'b1;
    cyc();
    RST = 1'b0;
    tod.TICK_1HZ = 1'b0;
    chk("mid_rst", now(), 24'h123456);
    chk("mid_rst_pm", tod.PM, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
